// File: rtl/bsg_counter_threshold_notify_if.sv
// Consumer-side event channel of bsg_counter_threshold_notify.
// The master (event generator) presents pending-event status; the slave
// (consumer) takes one event per cycle with yumi while v is high.
interface bsg_counter_threshold_notify_if #(
  parameter int unsigned width_p       = 10,
  parameter int unsigned max_pending_p = 3
);
  localparam int unsigned pending_width_lp = $clog2(max_pending_p + 1);

  logic                        v;
  logic                        yumi;
  logic [width_p-1:0]          count_snap;
  logic [pending_width_lp-1:0] pending;
  logic                        overrun;

  modport master (
    output v,
    output count_snap,
    output pending,
    output overrun,
    input  yumi
  );

  modport slave (
    input  v,
    input  count_snap,
    input  pending,
    input  overrun,
    output yumi
  );
endinterface

// File: rtl/bsg_counter_threshold_notify.sv
// Threshold event generator for a set/enable counter.
// Watches count_i, raises a hit on entry to the programmed threshold while
// armed, and queues hits as a saturating pending count drained via yumi.
// All outputs come straight from registers.
module bsg_counter_threshold_notify #(
  parameter int unsigned width_p       = 10,
  parameter int unsigned max_pending_p = 3,
  parameter bit          oneshot_p     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [width_p-1:0]   count_i,
  input  logic                 thresh_v_i,
  input  logic [width_p-1:0]   thresh_i,
  input  logic                 arm_i,
  input  logic                 disarm_i,
  bsg_counter_threshold_notify_if.master evt_if
);

  localparam int unsigned pending_width_lp = $clog2(max_pending_p + 1);
  localparam logic [pending_width_lp-1:0] pending_max_lp = pending_width_lp'(max_pending_p);
  localparam logic [pending_width_lp-1:0] pending_one_lp = pending_width_lp'(1);

  if (max_pending_p < 1) begin : g_bad_max_pending
    $error("bsg_counter_threshold_notify: max_pending_p must be at least 1");
  end

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } state_e;

  state_e                      state_q,      state_d;
  logic [width_p-1:0]          thresh_q,     thresh_d;
  logic [width_p-1:0]          prev_count_q, prev_count_d;
  logic                        prev_v_q,     prev_v_d;
  logic [pending_width_lp-1:0] pending_q,    pending_d;
  logic [width_p-1:0]          snap_q,       snap_d;
  logic                        overrun_q,    overrun_d;

  logic raw_hit;
  logic hit;
  logic pending_full;
  logic arm_accept;

  // Hit detection: entry into the threshold value only, never on a held value
  always_comb begin
    raw_hit      = prev_v_q & (count_i == thresh_q) & (count_i != prev_count_q);
    hit          = raw_hit & (state_q == ARMED);
    pending_full = (pending_q == pending_max_lp);
  end

  // Next-state logic for the arm FSM, history, threshold, pending and flags
  always_comb begin
    state_d      = state_q;
    thresh_d     = thresh_q;
    prev_count_d = count_i;
    prev_v_d     = 1'b1;
    pending_d    = pending_q;
    snap_d       = snap_q;
    overrun_d    = overrun_q;
    arm_accept   = 1'b0;

    // threshold loads take effect for the next compare, not this one
    if (thresh_v_i) begin
      thresh_d = thresh_i;
    end

    unique case (state_q)
      DISARMED: begin
        if (arm_i && !disarm_i) begin
          state_d    = ARMED;
          arm_accept = 1'b1;
        end
      end
      ARMED: begin
        if (disarm_i || (oneshot_p && hit)) begin
          state_d = DISARMED;
        end
      end
      default: state_d = DISARMED;
    endcase

    // a hit and a yumi in the same cycle cancel, even when saturated
    unique case ({hit, evt_if.yumi})
      2'b10: begin
        if (pending_full) begin
          overrun_d = 1'b1;
        end else begin
          pending_d = pending_q + pending_one_lp;
        end
      end
      2'b01:   pending_d = pending_q - pending_one_lp;
      default: pending_d = pending_q;
    endcase

    if (hit) begin
      snap_d = count_i;
    end

    // overrun cannot be set while disarmed, so the clear never races a set
    if (arm_accept) begin
      overrun_d = 1'b0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= DISARMED;
      thresh_q     <= '0;
      prev_count_q <= '0;
      prev_v_q     <= 1'b0;
      pending_q    <= '0;
      snap_q       <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      thresh_q     <= thresh_d;
      prev_count_q <= prev_count_d;
      prev_v_q     <= prev_v_d;
      pending_q    <= pending_d;
      snap_q       <= snap_d;
      overrun_q    <= overrun_d;
    end
  end

  assign evt_if.v          = (pending_q != '0);
  assign evt_if.pending    = pending_q;
  assign evt_if.count_snap = snap_q;
  assign evt_if.overrun    = overrun_q;

  // Consumer must only take an event that is actually pending
  assert property (@(posedge clk_i) disable iff (reset_i) !(evt_if.yumi && !evt_if.v))
    else $error("bsg_counter_threshold_notify: yumi asserted with no pending event");

endmodule

// File: tb/tb_bsg_counter_threshold_notify.sv
// Scoreboard bench: two instances (continuous and one-shot) share stimulus;
// a reference model predicts each cycle's outputs into per-instance queues
// that a negedge monitor pops and compares.
module tb_bsg_counter_threshold_notify;

  localparam int W  = 10;
  localparam int MP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cnt;
  logic         tv;
  logic [W-1:0] th;
  logic         arm;
  logic         dis;

  always #5 clk = ~clk;

  bsg_counter_threshold_notify_if #(.width_p(W), .max_pending_p(MP)) u_if0 ();
  bsg_counter_threshold_notify_if #(.width_p(W), .max_pending_p(MP)) u_if1 ();

  bsg_counter_threshold_notify #(.width_p(W), .max_pending_p(MP), .oneshot_p(1'b0)) dut0 (
    .clk_i(clk), .reset_i(rst), .count_i(cnt), .thresh_v_i(tv), .thresh_i(th),
    .arm_i(arm), .disarm_i(dis), .evt_if(u_if0)
  );

  bsg_counter_threshold_notify #(.width_p(W), .max_pending_p(MP), .oneshot_p(1'b1)) dut1 (
    .clk_i(clk), .reset_i(rst), .count_i(cnt), .thresh_v_i(tv), .thresh_i(th),
    .arm_i(arm), .disarm_i(dis), .evt_if(u_if1)
  );

  typedef struct {
    int v;
    int pend;
    int snap;
    int ovr;
  } exp_t;

  exp_t sbq[2][$];

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_armed [2];
  int m_pend  [2];
  int m_snap  [2];
  bit m_ovr   [2];
  int m_thresh;
  int m_prev;
  bit m_prev_v;

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%0d expected=%0d", name, k, $time, act, exp);
    end
  endtask

  // one clock of stimulus; predicts outputs after the coming edge
  task automatic step(input int c, input bit t_v, input int t, input bit a,
                      input bit d, input bit y_req, input bit r);
    bit   y   [2];
    bit   hit;
    bit   counted;
    exp_t e;
    rst = r;
    cnt = W'(c);
    tv  = t_v;
    th  = W'(t);
    arm = a;
    dis = d;
    for (int k = 0; k < 2; k++) y[k] = y_req && (m_pend[k] > 0) && !r;
    u_if0.yumi = y[0];
    u_if1.yumi = y[1];

    hit = m_prev_v && (c == m_thresh) && (c != m_prev);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_armed[k] = 0; m_pend[k] = 0; m_snap[k] = 0; m_ovr[k] = 0;
      end else begin
        counted = hit && m_armed[k];
        if (counted && !y[k]) begin
          if (m_pend[k] < MP) m_pend[k]++;
          else m_ovr[k] = 1;
        end else if (!counted && y[k]) begin
          m_pend[k]--;
        end
        if (counted) m_snap[k] = c;
        if (m_armed[k]) begin
          if (d || (k == 1 && counted)) m_armed[k] = 0;
        end else if (a && !d) begin
          m_armed[k] = 1;
          m_ovr[k]   = 0;
        end
      end
      e.v    = (m_pend[k] > 0) ? 1 : 0;
      e.pend = m_pend[k];
      e.snap = m_snap[k];
      e.ovr  = m_ovr[k] ? 1 : 0;
      sbq[k].push_back(e);
    end
    if (r) begin
      m_thresh = 0; m_prev = 0; m_prev_v = 0;
    end else begin
      if (t_v) m_thresh = t;
      m_prev   = c;
      m_prev_v = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cstep(input int c);
    step(c, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: compares every presented output against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (sbq[k].size() > 0) begin
          e = sbq[k].pop_front();
          if (k == 0) begin
            chk("v",       k, int'(u_if0.v),          e.v);
            chk("pending", k, int'(u_if0.pending),    e.pend);
            chk("snap",    k, int'(u_if0.count_snap), e.snap);
            chk("overrun", k, int'(u_if0.overrun),    e.ovr);
          end else begin
            chk("v",       k, int'(u_if1.v),          e.v);
            chk("pending", k, int'(u_if1.pending),    e.pend);
            chk("snap",    k, int'(u_if1.count_snap), e.snap);
            chk("overrun", k, int'(u_if1.overrun),    e.ovr);
          end
        end
      end
    end
  end

  initial begin
    int cur;
    int sel;
    u_if0.yumi = 1'b0;
    u_if1.yumi = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_armed[k] = 0; m_pend[k] = 0; m_snap[k] = 0; m_ovr[k] = 0;
    end
    m_thresh = 0; m_prev = 0; m_prev_v = 0;

    // reset
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // load threshold 5, arm, count 0..7, then take the event
    step(0, 1, 5, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) cstep(i);
    step(7, 0, 0, 0, 0, 1, 0);

    // hold at threshold, then re-enter
    cstep(4);
    for (int i = 0; i < 10; i++) cstep(5);
    cstep(6);
    cstep(5);

    // saturate pending and overrun; hit with yumi at saturation
    for (int i = 0; i < 4; i++) begin
      cstep(4);
      cstep(5);
    end
    cstep(4);
    step(5, 0, 0, 0, 0, 1, 0);
    step(5, 0, 0, 0, 1, 0, 0);
    step(5, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(5, 0, 0, 0, 0, 1, 0);

    // wrap-around hits at threshold 0; arm coincident with second hit
    step(1020, 1, 0, 1, 0, 0, 0);
    for (int i = 1021; i <= 1023; i++) cstep(i);
    cstep(0);
    for (int i = 1; i <= 3; i++) cstep(i);
    for (int i = 1020; i <= 1023; i++) cstep(i);
    step(0, 0, 0, 1, 0, 0, 0);
    cstep(1);

    // reset with events pending, then arm with count at threshold
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    cstep(0);

    // threshold load coincident with count reaching it
    step(7, 1, 7, 0, 0, 0, 0);
    cstep(7);
    cstep(8);
    cstep(7);
    for (int i = 0; i < 3; i++) step(7, 0, 0, 0, 0, 1, 0);

    // randomized traffic
    cur = 7;
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 4)      cur = (cur + 1) % 1024;
      else if (sel <= 6) cur = cur;
      else if (sel == 7) cur = int'($urandom_range(0, 12));
      else if (sel == 8) cur = 1022;
      else               cur = (cur + 1023) % 1024;
      step(cur,
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 12)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 199) == 0));
    end

    step(cur, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (sbq[k].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d actual=%0d expected=0", k, sbq[k].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
